// File: rtl/noc_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : noc_traffic_gen
// Description : Per-node AXI4-Stream traffic generator and response checker
//               for the NxN mesh NoC. Sends pkt_num packets of PKT_LEN beats
//               to a destination chosen by mode (self / fixed / incrementing
//               / LFSR random), with a programmable idle gap between packets.
//               The response side checks id, destination and packet framing,
//               and counts packets and protocol errors.
// Optional    : NOC_TGEN_SEQ_CHK_EN - adds a response data sequence check
//               (expected data register, resyncs to rsp_tdata+1 every beat).
// Ports       : clk, rst               - clock, synchronous active-high reset
//               start, mode, fixed_dest, pkt_num, gap - run control
//               req_*                  - AXI4-Stream request master
//               rsp_*                  - AXI4-Stream response slave
//               busy, done             - run status
//               tx_pkt_cnt, rx_pkt_cnt, err_cnt - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module noc_traffic_gen #(
    parameter int TDATA_W = 32,
    parameter int TID_W   = 6,
    parameter int TDEST_W = 5,
    parameter int TUSER_W = 5,
    parameter int NODE_ID = 0,
    parameter int NODE_N  = 16,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [TDEST_W-1:0]   fixed_dest,
    input  logic [CNT_W-1:0]     pkt_num,
    input  logic [3:0]           gap,
    output logic                 req_tvalid,
    input  logic                 req_tready,
    output logic [TDATA_W-1:0]   req_tdata,
    output logic                 req_tlast,
    output logic [TID_W-1:0]     req_tid,
    output logic [TDEST_W-1:0]   req_tdest,
    output logic [TUSER_W-1:0]   req_tuser,
    output logic [TDATA_W/8-1:0] req_tkeep,
    output logic [TDATA_W/8-1:0] req_tstrb,
    input  logic                 rsp_tvalid,
    output logic                 rsp_tready,
    input  logic [TDATA_W-1:0]   rsp_tdata,
    input  logic                 rsp_tlast,
    input  logic [TID_W-1:0]     rsp_tid,
    input  logic [TDEST_W-1:0]   rsp_tdest,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     tx_pkt_cnt,
    output logic [CNT_W-1:0]     rx_pkt_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int                  c_beat_w     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat  = c_beat_w'(PKT_LEN - 1);
    localparam logic [TDEST_W-1:0]  c_node_dest  = TDEST_W'(NODE_ID);
    localparam logic [TID_W-1:0]    c_node_tid   = TID_W'(NODE_ID);
    localparam logic [TUSER_W-1:0]  c_node_user  = TUSER_W'(NODE_ID);
    localparam logic [TDEST_W-1:0]  c_first_inc  = TDEST_W'((NODE_ID + 1) % NODE_N);
    localparam logic [TDEST_W-1:0]  c_dest_max   = TDEST_W'(NODE_N - 1);
    localparam logic [15:0]         c_lfsr_seed  = 16'hACE1 ^ 16'(NODE_ID);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [1:0]           r_mode;
    logic [TDEST_W-1:0]   r_fixed_dest;
    logic [CNT_W-1:0]     r_pkt_num;
    logic [3:0]           r_gap;
    logic [3:0]           r_gap_cnt;
    logic [CNT_W-1:0]     r_sent;
    logic [TDATA_W-1:0]   r_seq;
    logic [c_beat_w-1:0]  r_beat;
    logic [TDEST_W-1:0]   r_dest;
    logic [15:0]          r_lfsr;
    logic [CNT_W-1:0]     r_tx_cnt, r_rx_cnt, r_err_cnt;
    logic [c_beat_w-1:0]  r_rx_beat;

    logic                 w_start_ok, w_tx_hs, w_tx_eop, w_run_end;
    logic [15:0]          w_lfsr_nxt;
    logic [TDEST_W-1:0]   w_first_dest, w_next_dest;
    logic                 w_rx_at_last, w_rx_miss, w_rx_err, w_data_err;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + CNT_W'(1);
    endfunction

    function automatic logic [TDEST_W-1:0] lfsr_dest(input logic [15:0] v);
        return TDEST_W'(int'(v) % NODE_N);
    endfunction

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_tx_hs    = (r_state == ST_SEND) && req_tready;
    assign w_tx_eop   = w_tx_hs && (r_beat == c_last_beat);
    assign w_run_end  = w_tx_eop && ((r_sent + CNT_W'(1)) == r_pkt_num);
    // Fibonacci x^16+x^14+x^13+x^11+1 in right-shift form.
    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

    // First packet's destination uses the live inputs, since they are being
    // latched in the same cycle.
    always_comb begin
        w_first_dest = c_node_dest;
        case (mode)
            2'd0:    w_first_dest = c_node_dest;
            2'd1:    w_first_dest = fixed_dest;
            2'd2:    w_first_dest = c_first_inc;
            default: w_first_dest = lfsr_dest(r_lfsr);
        endcase
    end

    always_comb begin
        w_next_dest = r_dest;
        case (r_mode)
            2'd0:    w_next_dest = c_node_dest;
            2'd1:    w_next_dest = r_fixed_dest;
            2'd2:    w_next_dest = (r_dest == c_dest_max) ? '0 : r_dest + TDEST_W'(1);
            default: w_next_dest = lfsr_dest(w_lfsr_nxt);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_state_nxt = (pkt_num == '0) ? ST_DONE : ST_SEND;
            end
            ST_SEND: begin
                if (w_run_end)                      w_state_nxt = ST_DONE;
                else if (w_tx_eop && r_gap != 4'd0) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) w_state_nxt = ST_SEND;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= 2'd0;
            r_fixed_dest <= '0;
            r_pkt_num    <= '0;
            r_gap        <= 4'd0;
            r_gap_cnt    <= 4'd0;
            r_sent       <= '0;
            r_seq        <= '0;
            r_beat       <= '0;
            r_dest       <= '0;
            r_lfsr       <= c_lfsr_seed;
            r_tx_cnt     <= '0;
        end else begin
            if (w_start_ok) begin
                r_mode       <= mode;
                r_fixed_dest <= fixed_dest;
                r_pkt_num    <= pkt_num;
                r_gap        <= gap;
                r_sent       <= '0;
                r_beat       <= '0;
                r_dest       <= w_first_dest;
                r_tx_cnt     <= '0;
            end
            if (w_tx_hs) begin
                r_seq  <= r_seq + TDATA_W'(1);
                r_beat <= w_tx_eop ? '0 : r_beat + c_beat_w'(1);
            end
            if (w_tx_eop) begin
                r_tx_cnt <= sat_inc(r_tx_cnt);
                r_sent   <= r_sent + CNT_W'(1);
                r_lfsr   <= w_lfsr_nxt;
                r_dest   <= w_next_dest;
            end
            // GAP state lasts r_gap cycles: load gap-1, leave on zero.
            if (w_tx_eop)
                r_gap_cnt <= r_gap - 4'd1;
            else if (r_state == ST_GAP)
                r_gap_cnt <= r_gap_cnt - 4'd1;
        end
    end

    // ---------------------------------------------------------------- checker
    assign w_rx_at_last = (r_rx_beat == c_last_beat);
    assign w_rx_miss    = !rsp_tlast && w_rx_at_last;
    assign w_rx_err     = (rsp_tdest != c_node_dest) || (rsp_tid != c_node_tid) ||
                          (rsp_tlast && !w_rx_at_last) || w_rx_miss || w_data_err;

`ifdef NOC_TGEN_SEQ_CHK_EN
    logic [TDATA_W-1:0] r_exp_data;

    assign w_data_err = (rsp_tdata != r_exp_data);

    always_ff @(posedge clk) begin
        if (rst)             r_exp_data <= '0;
        else if (w_start_ok) r_exp_data <= '0;
        else if (rsp_tvalid) r_exp_data <= rsp_tdata + TDATA_W'(1);
    end
`else
    logic w_unused_rsp_tdata;

    assign w_data_err         = 1'b0;
    assign w_unused_rsp_tdata = ^rsp_tdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_beat <= '0;
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            // Frame counter resyncs on tlast and on a missing tlast.
            if (rsp_tvalid)
                r_rx_beat <= (rsp_tlast || w_rx_miss) ? '0 : r_rx_beat + c_beat_w'(1);
            if (w_start_ok) begin
                r_rx_cnt  <= '0;
                r_err_cnt <= '0;
            end else if (rsp_tvalid) begin
                if (rsp_tlast) r_rx_cnt  <= sat_inc(r_rx_cnt);
                if (w_rx_err)  r_err_cnt <= sat_inc(r_err_cnt);
            end
        end
    end

    assign req_tvalid = (r_state == ST_SEND);
    assign req_tdata  = r_seq;
    assign req_tlast  = req_tvalid && (r_beat == c_last_beat);
    assign req_tid    = c_node_tid;
    assign req_tdest  = r_dest;
    assign req_tuser  = c_node_user;
    assign req_tkeep  = {(TDATA_W/8){req_tvalid}};
    assign req_tstrb  = {(TDATA_W/8){req_tvalid}};
    assign rsp_tready = 1'b1;
    assign busy       = (r_state == ST_SEND) || (r_state == ST_GAP);
    assign done       = (r_state == ST_DONE);
    assign tx_pkt_cnt = r_tx_cnt;
    assign rx_pkt_cnt = r_rx_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
